// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI status codes, decoder FSM states and message-length helper
package midi_pkg;
   localparam logic [3:0] ST_NOTE_OFF = 4'h8;
   localparam logic [3:0] ST_NOTE_ON  = 4'h9;
   localparam logic [3:0] ST_BEND     = 4'hE;
   typedef enum logic [1:0] {S_IDLE, S_D1, S_D2} state_t;
   // Cx (program change) and Dx (channel pressure) carry one data byte, all other channel messages two
   function automatic logic [1:0] midi_data_len(input logic [3:0] nibble);
      return (nibble == 4'hC || nibble == 4'hD) ? 2'd1 : 2'd2;
   endfunction
endpackage

// File: rtl/midi_note_pitch_decoder.sv
// midi_note_pitch_decoder: MIDI byte stream -> monophonic note/pitch-bend/velocity/gate controls
//   CLK, RST          clock; asynchronous active-high reset
//   BYTE, BYTE_STB    received MIDI byte and its one-cycle strobe
//   NOTE, VELOCITY    last accepted note-on note number and velocity
//   PITCH             14-bit pitch bend, 8192 = centre
//   GATE              high while the current note is held
//   NOTE_ON_STB       one-cycle pulse per accepted note-on
module midi_note_pitch_decoder
   import midi_pkg::*;
#(
   parameter logic [3:0] CHANNEL = 4'd0,
   parameter bit         OMNI    = 1'b0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  BYTE,
   input  logic        BYTE_STB,
   output logic [6:0]  NOTE,
   output logic [13:0] PITCH,
   output logic [6:0]  VELOCITY,
   output logic        GATE,
   output logic        NOTE_ON_STB
);
   state_t      state_q, state_d;
   logic [7:0]  status_q, status_d;
   logic [6:0]  d1_q, d1_d, note_q, note_d, vel_q, vel_d;
   logic [13:0] pitch_q, pitch_d;
   logic        gate_q, gate_d, stb_q, stb_d;
   logic        hit;
   logic [3:0]  kind;
   assign hit  = OMNI || status_q[3:0] == CHANNEL;
   assign kind = status_q[7:4];
   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      d1_d     = d1_q;
      note_d   = note_q;
      vel_d    = vel_q;
      pitch_d  = pitch_q;
      gate_d   = gate_q;
      stb_d    = 1'b0;
      // realtime bytes (F8-FF) fall through untouched so a message in flight survives them
      if (BYTE_STB && BYTE < 8'hF8) begin
         if (BYTE[7]) begin
            // F0-F7 drop running status; 80-EF become the new running status
            state_d  = (BYTE[7:4] == 4'hF) ? S_IDLE : S_D1;
            status_d = BYTE;
         end else if (state_q == S_D1) begin
            d1_d    = BYTE[6:0];
            state_d = (midi_data_len(kind) == 2'd2) ? S_D2 : S_D1;
         end else if (state_q == S_D2) begin
            state_d = S_D1;
            if (hit && kind == ST_NOTE_ON && BYTE[6:0] != 7'd0) begin
               note_d = d1_q;
               vel_d  = BYTE[6:0];
               gate_d = 1'b1;
               stb_d  = 1'b1;
            end else if (hit && (kind == ST_NOTE_ON || kind == ST_NOTE_OFF) && d1_q == note_q) begin
               gate_d = 1'b0;
            end
            if (hit && kind == ST_BEND) pitch_d = {BYTE[6:0], d1_q};
         end
      end
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= S_IDLE;
         status_q <= 8'd0;
         d1_q     <= 7'd0;
         note_q   <= 7'd0;
         vel_q    <= 7'd0;
         pitch_q  <= 14'd8192;
         gate_q   <= 1'b0;
         stb_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         d1_q     <= d1_d;
         note_q   <= note_d;
         vel_q    <= vel_d;
         pitch_q  <= pitch_d;
         gate_q   <= gate_d;
         stb_q    <= stb_d;
      end
   end
   assign NOTE        = note_q;
   assign PITCH       = pitch_q;
   assign VELOCITY    = vel_q;
   assign GATE        = gate_q;
   assign NOTE_ON_STB = stb_q;
endmodule
